// File: rtl/adc_share_arbiter.sv
// Round-robin arbiter that shares one ADC req/rdy/dat handshake between NREQ requesters.
// Ready is resynchronised through two flops, and each handshake phase is bounded by TIMEOUT.
module adc_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int DW      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [NREQ-1:0]         err_o,
    output logic [DW-1:0]           data_o,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [7:0]              err_count,
    output logic                    adc_req,
    input  logic                    adc_rdy,
    input  logic [DW-1:0]           adc_dat
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TCNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TCNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   grant_r;
    logic [TW-1:0]   tcnt_r;
    logic            adc_req_r;
    logic            busy_r;
    logic [NREQ-1:0] ack_r;
    logic [NREQ-1:0] err_r;
    logic [DW-1:0]   data_r;
    logic [7:0]      err_count_r;
    logic            rdy_meta_r;
    logic            rdy_sync_r;
    logic [IW-1:0]   pick_s;

    // First requesting index strictly after ptr, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = {NREQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        pick_s = rr_pick(req_i, ptr_r);
    end

    // Two-flop synchroniser for the asynchronous ADC ready line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= adc_rdy;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    // Grant / conversion / release sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= PTR_INIT;
            grant_r     <= {IW{1'b0}};
            tcnt_r      <= TCNT_ZERO;
            adc_req_r   <= 1'b0;
            busy_r      <= 1'b0;
            ack_r       <= {NREQ{1'b0}};
            err_r       <= {NREQ{1'b0}};
            data_r      <= {DW{1'b0}};
            err_count_r <= 8'd0;
        end else begin
            ack_r <= {NREQ{1'b0}};
            err_r <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_r   <= pick_s;
                        ptr_r     <= pick_s;
                        tcnt_r    <= TCNT_ZERO;
                        adc_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (rdy_sync_r) begin
                        data_r    <= adc_dat;
                        ack_r     <= onehot(grant_r);
                        adc_req_r <= 1'b0;
                        tcnt_r    <= TCNT_ZERO;
                        state_r   <= ST_RELEASE;
                    end else if (tcnt_r == TCNT_LAST) begin
                        err_r       <= onehot(grant_r);
                        err_count_r <= sat_inc(err_count_r);
                        adc_req_r   <= 1'b0;
                        tcnt_r      <= TCNT_ZERO;
                        state_r     <= ST_RELEASE;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    // A ready line stuck high releases the ADC anyway, with one extra error.
                    if (!rdy_sync_r) begin
                        tcnt_r  <= TCNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (tcnt_r == TCNT_LAST) begin
                        err_r       <= onehot(grant_r);
                        err_count_r <= sat_inc(err_count_r);
                        tcnt_r      <= TCNT_ZERO;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_ONE;
                    end
                end
                default: begin
                    adc_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    tcnt_r    <= TCNT_ZERO;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o     = ack_r;
    assign err_o     = err_r;
    assign data_o    = data_r;
    assign busy      = busy_r;
    assign grant_id  = grant_r;
    assign err_count = err_count_r;
    assign adc_req   = adc_req_r;

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Self-checking bench for adc_share_arbiter: behavioural ADC and requesters with random
// delays/data, checked against a transaction-level round-robin and timing model.
module tb_adc_share_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int DW      = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] ack_o;
    logic [NREQ-1:0] err_o;
    logic [DW-1:0]   data_o;
    logic            busy;
    logic [1:0]      grant_id;
    logic [7:0]      err_count;
    logic            adc_req;
    logic            adc_rdy;
    logic [DW-1:0]   adc_dat;

    adc_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .ack_o(ack_o), .err_o(err_o),
        .data_o(data_o), .busy(busy), .grant_id(grant_id), .err_count(err_count),
        .adc_req(adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state: RR pointer, timeout count, last captured byte.
    int            m_ptr;
    int            m_errs;
    logic [DW-1:0] m_data;

    function automatic int rr_next(input logic [NREQ-1:0] pend, input int ptr);
        for (int i = 1; i <= NREQ; i++) begin
            if (pend[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int sat255(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Behavioural ADC: 0 = normal, 1 = never ready, 2 = ready stuck high after capture.
    int            adc_mode = 0;
    int            fix_dly = 0;
    bit            use_fix_dat = 1'b0;
    logic [DW-1:0] fix_dat = 8'h00;
    int            cur_dly = 1;
    logic [DW-1:0] cur_dat = 8'h00;
    int            acnt = 0;

    initial begin
        adc_rdy = 1'b0;
        adc_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (adc_req) begin
                if (acnt == 0) cur_dly = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 10));
                if (!adc_rdy && adc_mode != 1) begin
                    acnt++;
                    if (acnt >= cur_dly) begin
                        cur_dat = use_fix_dat ? fix_dat : DW'($urandom);
                        adc_dat = cur_dat;
                        adc_rdy = 1'b1;
                    end
                end
            end else begin
                acnt = 0;
                if (adc_mode != 2) adc_rdy = 1'b0;
            end
        end
    end

    typedef struct {
        int              cyc;
        int              rise;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [DW-1:0]   data;
        logic [1:0]      gid;
        logic            areq;
        logic            bsy;
        logic [7:0]      ecnt;
    } ev_t;

    ev_t  evq[$];
    int   rise_cyc = 0;
    logic req_prev = 1'b0;

    // Monitor: timestamps adc_req rises and records every ack/err pulse.
    always @(posedge clk) begin
        ev_t ev;
        #1;
        if (adc_req === 1'b1 && req_prev !== 1'b1) rise_cyc = cyc;
        req_prev = adc_req;
        if ((ack_o | err_o) != 4'b0000) begin
            checks++;
            if ((ack_o != 4'b0000 && err_o != 4'b0000) || !$onehot0(ack_o) || !$onehot0(err_o)) begin
                errors++;
                $display("FAIL pulse_shape: ack=%b err=%b, want a single one-hot pulse of one kind", ack_o, err_o);
            end
            ev.cyc = cyc; ev.rise = rise_cyc; ev.ack = ack_o; ev.err = err_o; ev.data = data_o;
            ev.gid = grant_id; ev.areq = adc_req; ev.bsy = busy; ev.ecnt = err_count;
            evq.push_back(ev);
        end
    end

    task automatic wait_ev(input int bound, output ev_t e, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk); #2;
            if (evq.size() > 0) begin
                e  = evq.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk); #2;
            if (busy === lvl) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_i = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (adc_req !== 1'b0 || busy !== 1'b0 || ack_o !== 4'b0000 || err_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: adc_req=%b busy=%b ack=%b err=%b, want all zero", adc_req, busy, ack_o, err_o);
        end
        checks++;
        if (data_o !== 8'h00 || grant_id !== 2'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h gid=%0d errcnt=%0d, want 0/0/0", data_o, grant_id, err_count);
        end
        @(negedge clk);
        reset = 1'b1;
        m_ptr = NREQ - 1; m_errs = 0; m_data = 8'h00;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || adc_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b adc_req=%b, want 0/0", busy, adc_req);
        end
        evq.delete();
    endtask

    task automatic test_fairness();
        ev_t e; bit ok; int k; logic [NREQ-1:0] want;
        adc_mode = 0; fix_dly = 0; use_fix_dat = 1'b0;
        @(negedge clk);
        req_i = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            wait_ev(200, e, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL fair_wait: slot %0d got no pulse in 200 cycles, want an ack", n);
                req_i = 4'b0000;
                return;
            end
            k = rr_next(4'b1111, m_ptr); m_ptr = k;
            want = 4'b0001 << k;
            checks++;
            if (e.ack !== want || e.err !== 4'b0000 || e.gid !== 2'(k)) begin
                errors++;
                $display("FAIL fair_order: slot %0d ack=%b gid=%0d, want ack=%b gid=%0d", n, e.ack, e.gid, want, k);
            end
            checks++;
            if (e.data !== cur_dat) begin
                errors++;
                $display("FAIL fair_data: slot %0d data=%h, want %h", n, e.data, cur_dat);
            end
            m_data = cur_dat;
            req_i[k] = 1'b0;
            if (n < 5) begin
                @(posedge clk); #2;
                req_i[k] = 1'b1;
            end
        end
        req_i = 4'b0000;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_single();
        ev_t e; bit ok; int t;
        adc_mode = 0; fix_dly = 3; use_fix_dat = 1'b1; fix_dat = 8'h5A;
        @(negedge clk);
        req_i = 4'b0001;
        wait_ev(200, e, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_wait: no pulse in 200 cycles, want ack");
            req_i = 4'b0000;
            return;
        end
        req_i = 4'b0000;
        m_ptr = rr_next(4'b0001, m_ptr); m_data = 8'h5A;
        checks++;
        if (e.ack !== 4'b0001 || e.err !== 4'b0000 || e.data !== 8'h5A) begin
            errors++;
            $display("FAIL single_ack: ack=%b err=%b data=%h, want 0001/0000/5a", e.ack, e.err, e.data);
        end
        checks++;
        if (e.cyc - e.rise !== 5) begin
            errors++;
            $display("FAIL single_latency: %0d cycles from adc_req to ack, want 5", e.cyc - e.rise);
        end
        checks++;
        if (e.areq !== 1'b0 || e.bsy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_cycle: adc_req=%b busy=%b in ack cycle, want 0/1", e.areq, e.bsy);
        end
        wait_busy(1'b0, 20, ok, t);
        checks++;
        if (!ok || t - e.cyc !== 3) begin
            errors++;
            $display("FAIL single_busy_drop: ok=%b after %0d cycles, want busy low 3 cycles after ack", ok, t - e.cyc);
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (evq.size() !== 0) begin
            errors++;
            $display("FAIL single_once: %0d extra pulses, want 0", evq.size());
            evq.delete();
        end
        use_fix_dat = 1'b0; fix_dly = 0;
    endtask

    task automatic test_random();
        ev_t e; bit ok; int k; logic [NREQ-1:0] pend; logic [NREQ-1:0] want;
        adc_mode = 0; fix_dly = 0; use_fix_dat = 1'b0;
        for (int r = 0; r < 12; r++) begin
            pend = 4'($urandom_range(1, 15));
            @(negedge clk);
            req_i = pend;
            while (pend != 4'b0000) begin
                wait_ev(200, e, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand_wait: round %0d pending=%b no pulse in 200 cycles", r, pend);
                    req_i = 4'b0000;
                    return;
                end
                k = rr_next(pend, m_ptr); m_ptr = k;
                want = 4'b0001 << k;
                checks++;
                if (e.ack !== want || e.err !== 4'b0000 || e.gid !== 2'(k)) begin
                    errors++;
                    $display("FAIL rand_grant: round %0d ack=%b gid=%0d, want ack=%b gid=%0d", r, e.ack, e.gid, want, k);
                end
                checks++;
                if (e.data !== cur_dat || e.cyc - e.rise !== cur_dly + 2) begin
                    errors++;
                    $display("FAIL rand_data: data=%h latency=%0d, want %h / %0d", e.data, e.cyc - e.rise, cur_dat, cur_dly + 2);
                end
                m_data = cur_dat;
                pend[k] = 1'b0;
                req_i[k] = 1'b0;
            end
            repeat (6) @(posedge clk);
        end
    endtask

    task automatic test_timeout();
        ev_t e; bit ok; int t;
        adc_mode = 1;
        @(negedge clk);
        req_i = 4'b0100;
        wait_busy(1'b1, 20, ok, t);
        @(negedge clk);
        req_i = 4'b1100;
        wait_ev(200, e, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_wait: no pulse in 200 cycles, want err");
            req_i = 4'b0000; adc_mode = 0;
            return;
        end
        m_ptr = rr_next(4'b0100, m_ptr);
        m_errs++;
        checks++;
        if (e.err !== 4'b0100 || e.ack !== 4'b0000 || e.cyc - e.rise !== TIMEOUT) begin
            errors++;
            $display("FAIL to_err: err=%b ack=%b after %0d cycles, want 0100/0000 after %0d", e.err, e.ack, e.cyc - e.rise, TIMEOUT);
        end
        checks++;
        if (e.ecnt !== 8'(sat255(m_errs)) || e.areq !== 1'b0 || e.data !== m_data) begin
            errors++;
            $display("FAIL to_state: errcnt=%0d adc_req=%b data=%h, want %0d/0/%h", e.ecnt, e.areq, e.data, sat255(m_errs), m_data);
        end
        req_i[2] = 1'b0;
        adc_mode = 0;
        wait_ev(200, e, ok);
        m_ptr = rr_next(4'b1000, m_ptr);
        checks++;
        if (!ok || e.ack !== 4'b1000) begin
            errors++;
            $display("FAIL to_next: ok=%b ack=%b, want requester 3 acked", ok, e.ack);
        end
        m_data = cur_dat;
        req_i = 4'b0000;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_boundary();
        ev_t e; bit ok;
        adc_mode = 0;
        for (int d = TIMEOUT - 2; d <= TIMEOUT - 1; d++) begin
            fix_dly = d;
            @(negedge clk);
            req_i = 4'b0001;
            wait_ev(200, e, ok);
            req_i = 4'b0000;
            m_ptr = rr_next(4'b0001, m_ptr);
            checks++;
            if (!ok || e.cyc - e.rise !== TIMEOUT) begin
                errors++;
                $display("FAIL edge_time: dly=%0d ok=%b at %0d cycles, want %0d", d, ok, e.cyc - e.rise, TIMEOUT);
            end
            if (d + 2 <= TIMEOUT) begin
                m_data = cur_dat;
                checks++;
                if (e.ack !== 4'b0001 || e.data !== cur_dat) begin
                    errors++;
                    $display("FAIL edge_ack: dly=%0d ack=%b data=%h, want 0001/%h", d, e.ack, e.data, cur_dat);
                end
            end else begin
                m_errs++;
                checks++;
                if (e.err !== 4'b0001 || e.ecnt !== 8'(sat255(m_errs)) || e.data !== m_data) begin
                    errors++;
                    $display("FAIL edge_err: dly=%0d err=%b errcnt=%0d data=%h, want 0001/%0d/%h", d, e.err, e.ecnt, e.data, sat255(m_errs), m_data);
                end
            end
            repeat (10) @(posedge clk);
            #2;
            checks++;
            if (evq.size() !== 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL edge_quiet: extra=%0d busy=%b, want 0/0", evq.size(), busy);
                evq.delete();
            end
        end
        fix_dly = 0;
    endtask

    task automatic test_stuck();
        ev_t e; ev_t e2; bit ok;
        adc_mode = 2; fix_dly = 2;
        @(negedge clk);
        req_i = 4'b0010;
        wait_ev(200, e, ok);
        req_i = 4'b0000;
        m_ptr = rr_next(4'b0010, m_ptr);
        m_data = cur_dat;
        checks++;
        if (!ok || e.ack !== 4'b0010 || e.data !== cur_dat) begin
            errors++;
            $display("FAIL stuck_ack: ok=%b ack=%b data=%h, want 0010/%h", ok, e.ack, e.data, cur_dat);
        end
        wait_ev(200, e2, ok);
        m_errs++;
        checks++;
        if (!ok || e2.err !== 4'b0010 || e2.cyc - e.cyc !== TIMEOUT) begin
            errors++;
            $display("FAIL stuck_err: ok=%b err=%b after %0d cycles, want 0010 after %0d", ok, e2.err, e2.cyc - e.cyc, TIMEOUT);
        end
        checks++;
        if (e2.ecnt !== 8'(sat255(m_errs)) || e2.bsy !== 1'b0 || e2.gid !== 2'd1) begin
            errors++;
            $display("FAIL stuck_state: errcnt=%0d busy=%b gid=%0d, want %0d/0/1", e2.ecnt, e2.bsy, e2.gid, sat255(m_errs));
        end
        adc_mode = 0; fix_dly = 0;
        repeat (8) @(posedge clk);
        #2;
        checks++;
        if (evq.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_quiet: extra=%0d busy=%b, want 0/0", evq.size(), busy);
            evq.delete();
        end
    endtask

    task automatic test_reset_mid();
        ev_t e; bit ok; int t; logic [NREQ-1:0] want;
        evq.delete();
        adc_mode = 1;
        @(negedge clk);
        req_i = 4'b1010;
        wait_busy(1'b1, 20, ok, t);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (adc_req !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: adc_req=%b, want 1 before reset", adc_req);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; adc_mode = 0;
        m_ptr = NREQ - 1; m_errs = 0; m_data = 8'h00;
        checks++;
        if (adc_req !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0 || data_o !== 8'h00 || evq.size() !== 0) begin
            errors++;
            $display("FAIL rmid_abort: adc_req=%b busy=%b errcnt=%0d data=%h pulses=%0d, want 0/0/0/00/0", adc_req, busy, err_count, data_o, evq.size());
            evq.delete();
        end
        for (int n = 0; n < 2; n++) begin
            wait_ev(200, e, ok);
            t = rr_next(req_i, m_ptr); m_ptr = t;
            want = 4'b0001 << t;
            checks++;
            if (!ok || e.ack !== want || e.ecnt !== 8'd0) begin
                errors++;
                $display("FAIL rmid_next: ok=%b ack=%b errcnt=%0d, want %b/0", ok, e.ack, e.ecnt, want);
            end
            m_data = cur_dat;
            req_i[t] = 1'b0;
        end
        req_i = 4'b0000;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_saturation();
        ev_t e; bit ok;
        adc_mode = 1;
        @(negedge clk);
        req_i = 4'b0001;
        for (int n = 0; n < 300; n++) begin
            wait_ev(200, e, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sat_wait: timeout %0d missing", n);
                req_i = 4'b0000; adc_mode = 0;
                return;
            end
            m_errs++;
            if (n == 299) req_i = 4'b0000;
            checks++;
            if (e.err !== 4'b0001 || e.ecnt !== 8'(sat255(m_errs))) begin
                errors++;
                $display("FAIL sat_count: n=%0d err=%b errcnt=%0d, want 0001/%0d", n, e.err, e.ecnt, sat255(m_errs));
            end
        end
        adc_mode = 0;
        repeat (8) @(posedge clk);
        #2;
        checks++;
        if (err_count !== 8'd255 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_final: errcnt=%0d busy=%b, want 255/0", err_count, busy);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req_i = 4'b0000;
        test_reset();
        test_fairness();
        test_single();
        test_random();
        test_timeout();
        test_boundary();
        test_stuck();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
